// File: rtl/lbp_window_sched.sv
// 3x3 window scheduler for LBP: raster-scans the interior of a DIM x DIM gray image and fetches neighbourhoods with column reuse.
// Optional build macro LBP_SCHED_PERF_EN adds the perf_stall counter output.
module lbp_window_sched #(
    parameter int IMG_LOG2 = 3,
    parameter int DW       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    gray_req,
    output logic [2*IMG_LOG2-1:0]   gray_addr,
    input  logic [DW-1:0]           gray_data,
    output logic                    win_valid,
    input  logic                    win_ready,
    output logic [9*DW-1:0]         win_data,
    output logic [2*IMG_LOG2-1:0]   win_addr,
    output logic                    busy,
    output logic                    done
`ifdef LBP_SCHED_PERF_EN
    ,
    output logic [15:0]             perf_stall
`endif
);

    localparam int AW = 2 * IMG_LOG2;
    localparam logic [IMG_LOG2-1:0] ONE      = IMG_LOG2'(1);
    localparam logic [IMG_LOG2-1:0] LAST_POS = IMG_LOG2'((1 << IMG_LOG2) - 2);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DRAIN   = 3'd2,
        S_PRESENT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              state_r, state_s;
    logic [IMG_LOG2-1:0] x_r, x_s, y_r, y_s;
    logic [1:0]          ro_r, ro_s, co_r, co_s;
    logic                gray_req_r, req_s;
    logic [AW-1:0]       gray_addr_r, addr_s;
    logic                win_valid_r, valid_s;
    logic [AW-1:0]       win_addr_r, win_addr_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;
    logic                shift_s;
    logic                cap_valid_r;
    logic [3:0]          cap_slot_r;
    logic [DW-1:0]       win_r [0:8];

    // Address of the pixel at window offset (co, ro) around centre (cx, cy).
    function automatic logic [AW-1:0] fetch_addr(input logic [IMG_LOG2-1:0] cx,
                                                 input logic [IMG_LOG2-1:0] cy,
                                                 input logic [1:0]          co,
                                                 input logic [1:0]          ro);
        logic [IMG_LOG2-1:0] col;
        logic [IMG_LOG2-1:0] row;
        col = cx - ONE + IMG_LOG2'(co);
        row = cy - ONE + IMG_LOG2'(ro);
        return {row, col};
    endfunction

    // Next-state and next-output decode; outputs are registered one stage later.
    always_comb begin
        state_s    = state_r;
        x_s        = x_r;
        y_s        = y_r;
        ro_s       = ro_r;
        co_s       = co_r;
        req_s      = 1'b0;
        addr_s     = gray_addr_r;
        valid_s    = 1'b0;
        win_addr_s = win_addr_r;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        shift_s    = 1'b0;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_s = S_FETCH;
                    x_s     = ONE;
                    y_s     = ONE;
                    ro_s    = 2'd0;
                    co_s    = 2'd0;
                    req_s   = 1'b1;
                    busy_s  = 1'b1;
                end else begin
                    done_s = (state_r == S_DONE);
                end
            end
            S_FETCH: begin
                busy_s = 1'b1;
                if ((ro_r == 2'd2) && (co_r == 2'd2)) begin
                    state_s = S_DRAIN;
                end else if (ro_r != 2'd2) begin
                    req_s = 1'b1;
                    ro_s  = ro_r + 2'd1;
                end else begin
                    req_s = 1'b1;
                    ro_s  = 2'd0;
                    co_s  = co_r + 2'd1;
                end
            end
            S_DRAIN: begin
                busy_s     = 1'b1;
                valid_s    = 1'b1;
                win_addr_s = {y_r, x_r};
                state_s    = S_PRESENT;
            end
            S_PRESENT: begin
                busy_s  = 1'b1;
                valid_s = 1'b1;
                if (!win_ready) begin
                    state_s = S_PRESENT;
                end else if (x_r != LAST_POS) begin
                    // In-row step: keep two columns, fetch only the new right column.
                    valid_s = 1'b0;
                    shift_s = 1'b1;
                    x_s     = x_r + ONE;
                    ro_s    = 2'd0;
                    co_s    = 2'd2;
                    req_s   = 1'b1;
                    state_s = S_FETCH;
                end else if (y_r != LAST_POS) begin
                    valid_s = 1'b0;
                    x_s     = ONE;
                    y_s     = y_r + ONE;
                    ro_s    = 2'd0;
                    co_s    = 2'd0;
                    req_s   = 1'b1;
                    state_s = S_FETCH;
                end else begin
                    valid_s = 1'b0;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    state_s = S_DONE;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
        if (req_s) begin
            addr_s = fetch_addr(x_s, y_s, co_s, ro_s);
        end else begin
            addr_s = gray_addr_r;
        end
    end

    // State, coordinate, output and window registers with read-data capture one cycle after issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            x_r         <= ONE;
            y_r         <= ONE;
            ro_r        <= 2'd0;
            co_r        <= 2'd0;
            gray_req_r  <= 1'b0;
            gray_addr_r <= '0;
            win_valid_r <= 1'b0;
            win_addr_r  <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cap_valid_r <= 1'b0;
            cap_slot_r  <= 4'd0;
            for (int k = 0; k < 9; k++) begin
                win_r[k] <= '0;
            end
        end else begin
            state_r     <= state_s;
            x_r         <= x_s;
            y_r         <= y_s;
            ro_r        <= ro_s;
            co_r        <= co_s;
            gray_req_r  <= req_s;
            gray_addr_r <= addr_s;
            win_valid_r <= valid_s;
            win_addr_r  <= win_addr_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            cap_valid_r <= gray_req_r;
            cap_slot_r  <= 4'(ro_r) * 4'd3 + 4'(co_r);
            if (shift_s) begin
                for (int r = 0; r < 3; r++) begin
                    win_r[3*r]     <= win_r[3*r + 1];
                    win_r[3*r + 1] <= win_r[3*r + 2];
                end
            end else if (cap_valid_r) begin
                win_r[cap_slot_r] <= gray_data;
            end
        end
    end

    assign gray_req  = gray_req_r;
    assign gray_addr = gray_addr_r;
    assign win_valid = win_valid_r;
    assign win_addr  = win_addr_r;
    assign busy      = busy_r;
    assign done      = done_r;

    for (genvar k = 0; k < 9; k++) begin : g_win
        assign win_data[DW*k +: DW] = win_r[k];
    end

`ifdef LBP_SCHED_PERF_EN
    logic [15:0] perf_stall_r;
    logic        accept_s;

    assign accept_s = start && ((state_r == S_IDLE) || (state_r == S_DONE));

    // Saturating count of PRESENT cycles the consumer held off.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_r <= 16'd0;
        end else if (accept_s) begin
            perf_stall_r <= 16'd0;
        end else if ((state_r == S_PRESENT) && !win_ready && (perf_stall_r != 16'hFFFF)) begin
            perf_stall_r <= perf_stall_r + 16'd1;
        end else begin
            perf_stall_r <= perf_stall_r;
        end
    end

    assign perf_stall = perf_stall_r;
`endif

endmodule

// File: tb/tb_lbp_window_sched.sv
// Self-checking bench for lbp_window_sched: ramp and random images against a 3x3 gather reference model.
module tb_lbp_window_sched;

    localparam int DIM = 8;
    localparam int NWIN = (DIM - 2) * (DIM - 2);

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        gray_req;
    logic [5:0]  gray_addr;
    logic [7:0]  gray_data;
    logic        win_valid;
    logic        win_ready;
    logic [71:0] win_data;
    logic [5:0]  win_addr;
    logic        busy;
    logic        done;
`ifdef LBP_SCHED_PERF_EN
    logic [15:0] perf_stall;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  img [0:DIM*DIM-1];
    logic [5:0]  rd_q [$];

    lbp_window_sched #(.IMG_LOG2(3), .DW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .gray_req  (gray_req),
        .gray_addr (gray_addr),
        .gray_data (gray_data),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_data  (win_data),
        .win_addr  (win_addr),
        .busy      (busy),
        .done      (done)
`ifdef LBP_SCHED_PERF_EN
        ,
        .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Gray memory: registered read, plus a trace of every issued address.
    always @(posedge clk) begin
        if (gray_req === 1'b1) begin
            gray_data <= img[gray_addr];
            rd_q.push_back(gray_addr);
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the 3x3 neighbourhood around (cx, cy), row-major, k=0 in the low byte.
    function automatic logic [71:0] ref_win(input int cx, input int cy);
        logic [71:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            w[8*k +: 8] = img[(cy - 1 + k / 3) * DIM + (cx - 1 + k % 3)];
        end
        return w;
    endfunction

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (win_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, 128'(win_valid), 128'd1);
    endtask

    // Full scan started at the current negedge; checks every accepted window in raster order.
    task automatic run_scan(input bit rnd_ready, input int restart_at,
                            output int first_valid, output int done_cyc, output int nwin,
                            output logic [71:0] first_win);
        int rel;
        int ex;
        int ey;
        start       = 1'b1;
        rel         = 0;
        nwin        = 0;
        first_valid = 0;
        done_cyc    = 0;
        first_win   = '0;
        while (rel < 3000 && done_cyc == 0) begin
            @(negedge clk);
            rel++;
            start = (rel == restart_at);
            if (rel == 1) begin
                check("busy_after_start", {126'd0, busy, done}, 128'b10);
            end
            if (win_valid === 1'b1) begin
                if (first_valid == 0) begin
                    first_valid = rel;
                    first_win   = win_data;
                end
                win_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (win_ready) begin
                    ex = 1 + nwin % (DIM - 2);
                    ey = 1 + nwin / (DIM - 2);
                    check("win_addr", 128'(win_addr), 128'(ey * DIM + ex));
                    check("win_data", 128'(win_data), 128'(ref_win(ex, ey)));
                    nwin++;
                end
            end else begin
                win_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (done === 1'b1) begin
                done_cyc = rel;
            end
        end
        check("scan_completes", 128'(done_cyc != 0), 128'd1);
        check("window_count", 128'(nwin), 128'(NWIN));
        win_ready = 1'b1;
    endtask

    int          fv, dc, nw;
    logic [71:0] fw;
    logic [71:0] snap_data;
    logic [5:0]  snap_addr;
    int          exp_addrs [12] = '{0, 8, 16, 1, 9, 17, 2, 10, 18, 3, 11, 19};

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        win_ready = 1'b1;
        for (int i = 0; i < DIM * DIM; i++) img[i] = 8'(i);
        repeat (3) @(negedge clk);
        check("reset_outputs", {gray_req, gray_addr, win_valid, win_data, win_addr, busy, done}, '0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_outputs", {gray_req, busy, done, win_valid}, '0);

        // Ramp image, consumer always ready.
        rd_q.delete();
        run_scan(1'b0, 0, fv, dc, nw, fw);
        check("first_valid_cycle", 128'(fv), 128'd11);
        check("done_cycle", 128'(dc), 128'd217);
        check("first_window", 128'(fw), 128'h12_11_10_0A_09_08_02_01_00);
        check("read_count", 128'(rd_q.size()), 128'((DIM - 2) * (9 + 3 * (DIM - 3))));
        for (int i = 0; i < 12; i++) begin
            check("read_addr", 128'(rd_q[i]), 128'(exp_addrs[i]));
        end
        check("done_idle", {gray_req, busy, done}, 128'b001);
`ifdef LBP_SCHED_PERF_EN
        check("perf_zero", 128'(perf_stall), 128'd0);
`endif

        // Back-pressure on the second window for 7 cycles.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid("wait_win1");
        @(negedge clk);
        wait_valid("wait_win2");
        snap_data = win_data;
        snap_addr = win_addr;
        check("win2_addr", 128'(win_addr), 128'd10);
        win_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("stall_valid", {win_valid, gray_req}, 128'b10);
            check("stall_data", 128'(win_data), 128'(snap_data));
            check("stall_addr", 128'(win_addr), 128'(snap_addr));
        end
        win_ready = 1'b1;
        @(negedge clk);
        check("after_stall_valid", 128'(win_valid), 128'd0);
`ifdef LBP_SCHED_PERF_EN
        check("perf_stall", 128'(perf_stall), 128'd7);
`endif
        for (int i = 0; i < 400 && done !== 1'b1; i++) @(negedge clk);
        check("stall_scan_done", 128'(done), 128'd1);

        // Reset during the fifth window's fetch, then a clean rescan.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int w = 0; w < 4; w++) begin
            wait_valid("wait_pre_reset");
            @(negedge clk);
        end
        check("fetching_5th", {gray_req, busy}, 128'b11);
        reset = 1'b1;
        @(negedge clk);
        check("midscan_reset", {gray_req, gray_addr, win_valid, win_data, win_addr, busy, done}, '0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_idle", {gray_req, busy, done}, '0);
        run_scan(1'b0, 0, fv, dc, nw, fw);
        check("rescan_first_valid", 128'(fv), 128'd11);

        // Start pulse while busy is ignored; start in DONE restarts.
        run_scan(1'b0, 5, fv, dc, nw, fw);
        check("busy_start_done_cycle", 128'(dc), 128'd217);

        // Random image with random consumer back-pressure.
        for (int i = 0; i < DIM * DIM; i++) img[i] = 8'($urandom_range(0, 255));
        run_scan(1'b1, 0, fv, dc, nw, fw);
        check("random_first_valid", 128'(fv), 128'd11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
